// File: rtl/idu_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the decode stage.
interface idu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        rd_we;
    logic        illegal;

    // Environment side: drives fetch beats and execute backpressure.
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr,
        input  rd, rs1, rs2, imm, typ, rd_we, illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr,
        output rd, rs1, rs2, imm, typ, rd_we, illegal
    );
endinterface

// File: rtl/idu.sv
// RV32I instruction decode stage: decodes on entry, buffers in main + skid entries.
module idu #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    idu_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned TYP_W = 3;

    localparam logic [TYP_W-1:0] T_R   = 3'd0;
    localparam logic [TYP_W-1:0] T_I   = 3'd1;
    localparam logic [TYP_W-1:0] T_S   = 3'd2;
    localparam logic [TYP_W-1:0] T_B   = 3'd3;
    localparam logic [TYP_W-1:0] T_U   = 3'd4;
    localparam logic [TYP_W-1:0] T_J   = 3'd5;
    localparam logic [TYP_W-1:0] T_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic [TYP_W-1:0] typ;
        logic             rd_we;
        logic             illegal;
    } entry_t;

    // Full decode of one beat into a buffer entry.
    function automatic entry_t decode(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
        entry_t           e;
        logic [TYP_W-1:0] t;
        e.pc    = pc;
        e.instr = instr;
        e.rd    = instr[11:7];
        e.rs1   = instr[19:15];
        e.rs2   = instr[24:20];
        case (instr[6:0])
            7'b0110011:                                             t = T_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: t = T_I;
            7'b0100011:                                             t = T_S;
            7'b1100011:                                             t = T_B;
            7'b0110111, 7'b0010111:                                 t = T_U;
            7'b1101111:                                             t = T_J;
            default:                                                t = T_ILL;
        endcase
        if (instr[1:0] != 2'b11) begin
            t = T_ILL;
        end
        case (t)
            T_I:     e.imm = {{20{instr[31]}}, instr[31:20]};
            T_S:     e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            T_B:     e.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            T_U:     e.imm = {instr[31:12], 12'b0};
            T_J:     e.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: e.imm = '0;
        endcase
        e.typ     = t;
        e.illegal = (t == T_ILL);
        e.rd_we   = ((t == T_R) || (t == T_I) || (t == T_U) || (t == T_J)) && (e.rd != '0);
        return e;
    endfunction

    localparam entry_t RESET_ENTRY = decode(32'h0, NOP_INSTR);

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   accept;
    logic   deq;

    // Decode the incoming beat.
    always_comb begin
        in_entry = decode(bus.in_pc, bus.in_instr);
    end

    // Buffer control: flush first, then refill main, shift skid, or park in skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        accept       = bus.in_valid & ready_q & ~flush_i;
        deq          = main_valid_q & bus.out_ready;

        if (flush_i) begin
            main_valid_d  = 1'b0;
            skid_valid_d  = 1'b0;
            main_d.instr  = NOP_INSTR;
            main_d.rd_we  = 1'b0;
            main_d.illegal = 1'b0;
        end else if (!main_valid_q || (deq && !skid_valid_q)) begin
            if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d   = 1'b0;
                main_d.instr   = NOP_INSTR;
                main_d.rd_we   = 1'b0;
                main_d.illegal = 1'b0;
            end
        end else if (deq) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end

        ready_d = ~skid_valid_d;
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= RESET_ENTRY;
            skid_q       <= RESET_ENTRY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.out_instr = main_q.instr;
    assign bus.rd        = main_q.rd;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.imm       = main_q.imm;
    assign bus.typ       = main_q.typ;
    assign bus.rd_we     = main_q.rd_we;
    assign bus.illegal   = main_q.illegal;
endmodule
